stage1_hazard_ctrl: RTL
=======================

Name: stage1_hazard_ctrl

Overview:
- Sequencing controller for the decode stage of the 3-stage pipeline.
- Examines the stage-1 instruction against the stage-2 instruction and decides, each cycle, whether the PC advances and whether the stage-1→stage-2 register loads.
- Decides whether a bubble (NOP) is injected into stage 2.
- Covers cache-miss freezes, load-use hazards and branch/jump redirect flushes, and keeps saturating performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- s1_inst  input  32  instruction currently in stage 1.
- s1_valid  input  1  stage-1 instruction is real (not a bubble).
- s2_rd  input  5  destination register of the stage-2 instruction.
- s2_is_load  input  1  stage-2 instruction is a load.
- s2_valid  input  1  stage-2 instruction is real.
- redirect  input  1  stage 2 resolved a taken branch, JAL or JALR this cycle.
- icache_stall  input  1  instruction cache miss in progress.
- dcache_stall  input  1  data cache miss in progress.
- pc_en  output  1  PC register loads its next value.
- s1_en  output  1  stage-1→stage-2 pipeline register loads.
- s2_bubble  output  1  stage-2 register loads a NOP instead of stage-1 contents.
- state  output  2  current FSM state: BOOT=0, RUN=1, MEM_WAIT=2, FLUSH=3.
- stall_cycles  output  CNT_W  cycles with pc_en=0 after BOOT.
- flush_count  output  CNT_W  number of redirects accepted.

Behaviour:
- Register usage is decoded from s1_inst[6:0]:
  - R-type, branch, store: use rs1 and rs2.
  - I-type ALU, load, JALR: use rs1 only.
  - LUI, AUIPC, JAL, unknown opcode: use none.
- load_use = s1_valid & s2_valid & s2_is_load & (s2_rd != 0) & ((rs1 used & s1_inst[19:15]==s2_rd) | (rs2 used & s1_inst[24:20]==s2_rd)).
- mem_stall = icache_stall | dcache_stall.
- Reset (async, any time including mid-stall or mid-flush):
  - state=BOOT, counters=0.
  - Outputs while reset_n=0: pc_en=0, s1_en=0, s2_bubble=1.
- BOOT:
  - Outputs pc_en=1, s1_en=1, s2_bubble=1 (the first fetch has not returned yet).
  - Next state RUN unconditionally, even if mem_stall is asserted.
- RUN (Mealy outputs, priority order):
  1. mem_stall: pc_en=0, s1_en=0, s2_bubble=0 (freeze the whole pipe). Next MEM_WAIT.
  2. redirect: pc_en=1 (load target), s1_en=1, s2_bubble=1 (kill the wrong-path stage-1 instruction). flush_count+1. Next FLUSH.
  3. load_use: pc_en=0, s1_en=0, s2_bubble=1 (hold stage 1, one bubble). Stay RUN. The hazard clears next cycle because stage 2 then holds the bubble.
  4. Otherwise: pc_en=1, s1_en=1, s2_bubble=0.
- MEM_WAIT:
  - While mem_stall: pc_en=0, s1_en=0, s2_bubble=0.
  - When mem_stall deasserts: evaluate exactly as RUN priorities 2–4 in that same cycle, with the same next-state rules.
  - redirect is held stable by the frozen stage 2, so it is not lost.
- FLUSH:
  - Squashes the second wrong-path instruction, which the synchronous icache returns one cycle after redirect.
  - If mem_stall: freeze as in MEM_WAIT, remain FLUSH.
  - Else: pc_en=1, s1_en=1, s2_bubble=1, next RUN.
  - A redirect in FLUSH is ignored: stage 2 holds a bubble, and stage 2 guarantees redirect=0 for a bubble.
- Counters:
  - stall_cycles increments on every cycle with state!=BOOT, reset_n=1 and pc_en=0.
  - Both counters saturate at all-ones and never wrap.
- No combinational path from the counters to any input. Outputs depend only on state and current inputs.

Test Plan:
- Reset then release, with mem_stall=0: cycle 0 after release gives state=BOOT, pc_en=1, s2_bubble=1. Cycle 1 gives state=RUN, s2_bubble=0. Asserting reset_n=0 mid-MEM_WAIT immediately gives pc_en=0, s2_bubble=1, counters=0.
- Load-use: s2 = lw x5 (s2_is_load=1, s2_rd=5, s2_valid=1), s1 = add x6,x5,x7 → exactly one cycle with pc_en=0, s1_en=0, s2_bubble=1, stall_cycles=1.
  - Same with s2_rd=0, or with s1 = lui x5 → no stall.
  - Same with s1 = sw x5,0(x8) (rs2=x5) → stall.
- Redirect in RUN → s2_bubble=1 for 2 consecutive cycles (RUN then FLUSH), pc_en=1 both cycles, flush_count=1, then RUN with s2_bubble=0.
- dcache_stall held 4 cycles while a load-use pair is present → 4 frozen cycles (s2_bubble=0), then on release 1 load-use bubble. stall_cycles=5.
- Redirect and icache_stall asserted together in RUN → freeze (MEM_WAIT). When the stall drops, redirect is processed: FLUSH follows, flush_count=1.
- Force stall_cycles to all-ones via a long stall with CNT_W=4 (20 stall cycles) → value holds at 15.

Source files
------------

// File: rtl/stage1_hazard_ctrl.sv
// stage1_hazard_ctrl: decode-stage sequencing for the 3-stage pipeline
// (freeze, load-use bubble, redirect flush, saturating counters). Rev 1.0
`default_nettype none

module stage1_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      s1_inst,
  input  logic             s1_valid,
  input  logic [4:0]       s2_rd,
  input  logic             s2_is_load,
  input  logic             s2_valid,
  input  logic             redirect,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  output logic             pc_en,
  output logic             s1_en,
  output logic             s2_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     cur_state;
  state_t     next_state;
  logic       use_rs1;
  logic       use_rs2;
  logic       load_use;
  logic       mem_stall;
  logic       flush_inc;
  logic       stall_inc;
  logic       unused_inst_bits;

  assign unused_inst_bits = ^{s1_inst[31:25], s1_inst[14:7]};

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (s1_inst[6:0])
      OP_RTYPE, OP_BRANCH, OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_IALU, OP_LOAD, OP_JALR: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign load_use = s1_valid & s2_valid & s2_is_load & (s2_rd != 5'd0) &
                    ((use_rs1 & (s1_inst[19:15] == s2_rd)) |
                     (use_rs2 & (s1_inst[24:20] == s2_rd)));

  assign mem_stall = icache_stall | dcache_stall;

  // Mealy decision; reset_n overrides so the pipe stays quiet while held in reset.
  always_comb begin
    pc_en      = 1'b1;
    s1_en      = 1'b1;
    s2_bubble  = 1'b0;
    flush_inc  = 1'b0;
    next_state = cur_state;
    case (cur_state)
      BOOT: begin
        s2_bubble  = 1'b1;
        next_state = RUN;
      end
      RUN, MEM_WAIT: begin
        if (mem_stall) begin
          pc_en      = 1'b0;
          s1_en      = 1'b0;
          next_state = MEM_WAIT;
        end else if (redirect) begin
          s2_bubble  = 1'b1;
          flush_inc  = 1'b1;
          next_state = FLUSH;
        end else if (load_use) begin
          pc_en      = 1'b0;
          s1_en      = 1'b0;
          s2_bubble  = 1'b1;
          next_state = RUN;
        end else begin
          next_state = RUN;
        end
      end
      FLUSH: begin
        if (mem_stall) begin
          pc_en = 1'b0;
          s1_en = 1'b0;
        end else begin
          s2_bubble  = 1'b1;
          next_state = RUN;
        end
      end
      default: next_state = BOOT;
    endcase
    if (!reset_n) begin
      pc_en     = 1'b0;
      s1_en     = 1'b0;
      s2_bubble = 1'b1;
      flush_inc = 1'b0;
    end
  end

  assign stall_inc = (cur_state != BOOT) & ~pc_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state    <= BOOT;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      cur_state <= next_state;
      if (stall_inc && stall_cycles != CNT_MAX)
        stall_cycles <= stall_cycles + CNT_ONE;
      if (flush_inc && flush_count != CNT_MAX)
        flush_count <= flush_count + CNT_ONE;
    end
  end

  assign state = cur_state;

endmodule

`default_nettype wire
